// File: rtl/stage_memory.sv
// Memory stage: exception-cause types shared with the pipeline, and the load/store engine.
// Latency: one cycle to the write stage; a bus access adds one cycle per unacknowledged request cycle.
// Backpressure: mem_stall holds execute while a request is outstanding; a flush drains the bus first.

package stage_memory_pkg;
    typedef logic [3:0] ecause_t;
    localparam ecause_t ECAUSE_LALIGN = 4'd4;
    localparam ecause_t ECAUSE_SALIGN = 4'd6;
endpackage

module stage_memory
    import stage_memory_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    // from execute
    input  logic        mem_valid,
    input  logic        mem_exc,
    input  ecause_t     mem_exc_cause,
    input  logic [31:2] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    input  logic [4:0]  wb_reg,
    // from write stage
    input  logic        wb_exc,
    // data bus
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:2] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    // to execute / forwarding
    output logic        mem_stall,
    output logic [31:0] mem_forward_data,
    // to write stage
    output logic        wb_valid,
    output logic        wb_exc_r,
    output ecause_t     wb_exc_cause,
    output logic [31:2] wb_pc,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg_r
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        acc;
    logic        align_fault;
    logic        exc;
    ecause_t     cause;
    logic        req_idle;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rdata_sh;
    logic [31:0] load_data;

    // Bus fields captured at launch so an outstanding request cannot drift if
    // execute changes its outputs around a flush.
    logic        hold_we;
    logic [31:2] hold_addr;
    logic [3:0]  hold_be;
    logic [31:0] hold_wdata;

    assign acc = mem_valid & (mem_read | mem_write);

    // Misalignment is only reported when no earlier exception is already travelling.
    assign align_fault = acc & ~mem_exc &
                         (((mem_width == 2'd1) & mem_data0[0]) |
                          ((mem_width == 2'd2) & (mem_data0[1:0] != 2'b00)));

    assign exc   = mem_exc | align_fault;
    assign cause = mem_exc ? mem_exc_cause : (mem_read ? ECAUSE_LALIGN : ECAUSE_SALIGN);

    // New requests are suppressed while reset is held so a reset mid-access drops the bus.
    assign req_idle = acc & ~exc & ~wb_exc & ~reset;

    // Byte enables and lane-replicated store data from width and low address bits.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_data1;
        case (mem_width)
            2'd0: begin
                be_c    = 4'b0001 << mem_data0[1:0];
                wdata_c = {4{mem_data1[7:0]}};
            end
            2'd1: begin
                be_c    = 4'b0011 << mem_data0[1:0];
                wdata_c = {2{mem_data1[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = mem_data1;
            end
        endcase
    end

    assign rdata_sh = dbus_rdata >> {mem_data0[1:0], 3'b000};

    // Load data: align the addressed lane down, then truncate and extend to width.
    always_comb begin
        load_data = rdata_sh;
        case (mem_width)
            2'd0:    load_data = mem_extend ? {{24{rdata_sh[7]}}, rdata_sh[7:0]}
                                            : {24'd0, rdata_sh[7:0]};
            2'd1:    load_data = mem_extend ? {{16{rdata_sh[15]}}, rdata_sh[15:0]}
                                            : {16'd0, rdata_sh[15:0]};
            default: load_data = rdata_sh;
        endcase
    end

    // Request and next-state logic; BUSY and DRAIN keep requesting until acknowledged.
    always_comb begin
        state_nxt = state;
        dbus_req  = 1'b0;
        case (state)
            ST_IDLE: begin
                dbus_req = req_idle;
                if (req_idle & ~dbus_ack)
                    state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                dbus_req = 1'b1;
                if (dbus_ack)
                    state_nxt = ST_IDLE;
                else if (wb_exc)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                dbus_req = 1'b1;
                if (dbus_ack)
                    state_nxt = ST_IDLE;
            end
            default: begin
                dbus_req  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dbus_we    = (state == ST_IDLE) ? mem_write          : hold_we;
    assign dbus_addr  = (state == ST_IDLE) ? mem_data0[31:2]    : hold_addr;
    assign dbus_be    = (state == ST_IDLE) ? be_c               : hold_be;
    assign dbus_wdata = (state == ST_IDLE) ? wdata_c            : hold_wdata;

    assign mem_stall        = dbus_req & ~dbus_ack;
    assign mem_forward_data = mem_read ? load_data : mem_data0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Capture the bus fields on the cycle a request launches from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_be    <= '0;
            hold_wdata <= '0;
        end else if (state == ST_IDLE) begin
            hold_we    <= mem_write;
            hold_addr  <= mem_data0[31:2];
            hold_be    <= be_c;
            hold_wdata <= wdata_c;
        end
    end

    // Write-stage pipeline register; a drained access retires nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_exc_r     <= 1'b0;
            wb_exc_cause <= '0;
            wb_pc        <= '0;
            wb_data      <= '0;
            wb_reg_r     <= '0;
        end else begin
            wb_valid     <= mem_valid & ~mem_stall & ~exc & ~wb_exc & (state != ST_DRAIN);
            wb_exc_r     <= exc & ~mem_stall & ~wb_exc;
            wb_exc_cause <= cause;
            if (!mem_stall) begin
                wb_pc    <= mem_pc;
                wb_reg_r <= wb_reg;
                wb_data  <= (mem_read & ~exc) ? load_data : mem_data0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed load/store/fault/flush vectors.
// Write-stage outputs are checked by a scoreboard monitor; bus-side values inline.
// Every bus wait is bounded by a cycle budget.

module tb_stage_memory;
    import stage_memory_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_exc;
    ecause_t     mem_exc_cause;
    logic [31:2] mem_pc;
    logic [31:0] mem_data0;
    logic [31:0] mem_data1;
    logic        mem_read;
    logic        mem_write;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic [4:0]  wb_reg;
    logic        wb_exc;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:2] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [31:0] mem_forward_data;
    logic        wb_valid;
    logic        wb_exc_r;
    ecause_t     wb_exc_cause;
    logic [31:2] wb_pc;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg_r;

    stage_memory dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause),
        .mem_pc(mem_pc), .mem_data0(mem_data0), .mem_data1(mem_data1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_extend(mem_extend),
        .mem_width(mem_width), .wb_reg(wb_reg), .wb_exc(wb_exc),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
        .mem_forward_data(mem_forward_data), .wb_valid(wb_valid),
        .wb_exc_r(wb_exc_r), .wb_exc_cause(wb_exc_cause), .wb_pc(wb_pc),
        .wb_data(wb_data), .wb_reg_r(wb_reg_r)
    );

    typedef struct {
        logic        v;
        logic        e;
        ecause_t     c;
        logic [31:2] pc;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic v, input logic e, input ecause_t c,
                            input logic [31:2] pc, input logic [31:0] data, input logic [4:0] rd);
        exp_t x;
        x.v = v; x.e = e; x.c = c; x.pc = pc; x.data = data; x.rd = rd;
        exp_q.push_back(x);
    endtask

    task automatic set_idle();
        mem_valid = 0; mem_exc = 0; mem_exc_cause = '0; mem_pc = '0;
        mem_data0 = 0; mem_data1 = 0; mem_read = 0; mem_write = 0;
        mem_extend = 0; mem_width = 2'd0; wb_reg = 0; wb_exc = 0; dbus_ack = 0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] w, input logic ext,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:2] pc,
                          input logic [4:0] rg, input logic ein, input ecause_t cin);
        mem_valid = 1; mem_read = rd; mem_write = wr; mem_width = w; mem_extend = ext;
        mem_data0 = d0; mem_data1 = d1; mem_pc = pc; wb_reg = rg;
        mem_exc = ein; mem_exc_cause = cin;
    endtask

    // Runs the current op until mem_stall drops. ack_dly<0 means never ack;
    // flush_cyc<0 means no write-stage flush.
    task automatic exec_op(input int ack_dly, input int flush_cyc, input int exp_stalls,
                           input logic exp_req, input logic [31:2] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_we, input logic [31:0] exp_fwd);
        int  cyc = 0;
        int  stalls = 0;
        bit  done = 0;
        while (!done) begin
            dbus_ack = (ack_dly >= 0) && (cyc == ack_dly);
            wb_exc   = (flush_cyc >= 0) && (cyc == flush_cyc);
            @(negedge clk);
            if (cyc == 0) begin
                check("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
                check("mem_forward_data", mem_forward_data, exp_fwd);
                if (exp_req) begin
                    check("dbus_addr", {2'b00, dbus_addr}, {2'b00, exp_addr});
                    check("dbus_be", {28'd0, dbus_be}, {28'd0, exp_be});
                    check("dbus_we", {31'd0, dbus_we}, {31'd0, exp_we});
                    if (exp_we)
                        check("dbus_wdata", dbus_wdata, exp_wdata);
                end
            end else if (exp_req) begin
                check("dbus_req_held", {31'd0, dbus_req}, 32'd1);
                check("dbus_addr_held", {2'b00, dbus_addr}, {2'b00, exp_addr});
                check("dbus_be_held", {28'd0, dbus_be}, {28'd0, exp_be});
            end
            if (mem_stall) stalls++;
            else done = 1;
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > 20) begin
                check("bus_timeout", 32'd1, 32'd0);
                done = 1;
            end
        end
        check("stall_cycles", stalls, exp_stalls);
        set_idle();
    endtask

    // Scoreboard monitor: every write-stage output must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (wb_valid || wb_exc_r)) begin
            exp_t x;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got valid=%0b exc=%0b data=0x%08h, expected no output",
                         wb_valid, wb_exc_r, wb_data);
            end else begin
                x = exp_q.pop_front();
                if (wb_valid !== x.v || wb_exc_r !== x.e || wb_pc !== x.pc ||
                    wb_data !== x.data || wb_reg_r !== x.rd ||
                    (x.e && wb_exc_cause !== x.c)) begin
                    n_bad++;
                    $display("FAIL wb_out: got v=%0b e=%0b c=%0d pc=%h data=%h rd=%0d, expected v=%0b e=%0b c=%0d pc=%h data=%h rd=%0d",
                             wb_valid, wb_exc_r, wb_exc_cause, wb_pc, wb_data, wb_reg_r,
                             x.v, x.e, x.c, x.pc, x.data, x.rd);
                end
            end
        end
    end

    initial begin
        reset = 1;
        dbus_rdata = 0;
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_exc_r", {31'd0, wb_exc_r}, 32'd0);
        check("rst_wb_cause", {28'd0, wb_exc_cause}, 32'd0);
        check("rst_wb_pc", {2'b00, wb_pc}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_reg", {27'd0, wb_reg_r}, 32'd0);
        check("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk);
        #1 reset = 0;

        // LB 0x1003, sign-extend, zero-wait
        dbus_rdata = 32'h80FF_FFFF;
        set_op(1, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 30'h100, 5'd5, 0, '0);
        push_exp(1, 0, '0, 30'h100, 32'hFFFF_FF80, 5'd5);
        exec_op(0, -1, 0, 1, 30'h400, 4'b1000, 32'h0, 0, 32'hFFFF_FF80);

        // SH 0x2002, ack after 3 stall cycles
        set_op(0, 1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 30'h101, 5'd0, 0, '0);
        push_exp(1, 0, '0, 30'h101, 32'h0000_2002, 5'd0);
        exec_op(3, -1, 3, 1, 30'h800, 4'b1100, 32'hABCD_ABCD, 1, 32'h0000_2002);

        // LW 0x0006: misaligned load fault, no request
        dbus_rdata = 32'h0;
        set_op(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0, 30'h102, 5'd3, 0, '0);
        push_exp(0, 1, ECAUSE_LALIGN, 30'h102, 32'h0000_0006, 5'd3);
        exec_op(-1, -1, 0, 0, 30'h0, 4'h0, 32'h0, 0, 32'h0);

        // LW 0x100 flushed while BUSY: drains to ack, retires nothing
        dbus_rdata = 32'h1122_3344;
        set_op(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 30'h103, 5'd4, 0, '0);
        exec_op(3, 1, 3, 1, 30'h040, 4'b1111, 32'h0, 0, 32'h1122_3344);

        // Back-to-back LHU 0x10 then ADD, both zero-wait
        dbus_rdata = 32'hBEEF_8001;
        set_op(1, 0, 2'd1, 0, 32'h0000_0010, 32'h0, 30'h104, 5'd7, 0, '0);
        push_exp(1, 0, '0, 30'h104, 32'h0000_8001, 5'd7);
        exec_op(0, -1, 0, 1, 30'h004, 4'b0011, 32'h0, 0, 32'h0000_8001);
        set_op(0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 30'h105, 5'd8, 0, '0);
        push_exp(1, 0, '0, 30'h105, 32'h0000_1234, 5'd8);
        exec_op(-1, -1, 0, 0, 30'h0, 4'h0, 32'h0, 0, 32'h0000_1234);

        // SW 0x3000, one wait cycle
        set_op(0, 1, 2'd2, 0, 32'h0000_3000, 32'hDEAD_BEEF, 30'h106, 5'd0, 0, '0);
        push_exp(1, 0, '0, 30'h106, 32'h0000_3000, 5'd0);
        exec_op(1, -1, 1, 1, 30'hC00, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0000_3000);

        // SB 0x4001: lane 1, replicated byte
        set_op(0, 1, 2'd0, 0, 32'h0000_4001, 32'h0000_00A5, 30'h107, 5'd0, 0, '0);
        push_exp(1, 0, '0, 30'h107, 32'h0000_4001, 5'd0);
        exec_op(0, -1, 0, 1, 30'h1000, 4'b0010, 32'hA5A5_A5A5, 1, 32'h0000_4001);

        // SH 0x2001: misaligned store fault
        set_op(0, 1, 2'd1, 0, 32'h0000_2001, 32'h0000_5555, 30'h108, 5'd0, 0, '0);
        push_exp(0, 1, ECAUSE_SALIGN, 30'h108, 32'h0000_2001, 5'd0);
        exec_op(-1, -1, 0, 0, 30'h0, 4'h0, 32'h0, 0, 32'h0000_2001);

        // LH 0x0002 sign-extended from the upper half
        dbus_rdata = 32'h8001_0000;
        set_op(1, 0, 2'd1, 1, 32'h0000_0002, 32'h0, 30'h109, 5'd9, 0, '0);
        push_exp(1, 0, '0, 30'h109, 32'hFFFF_8001, 5'd9);
        exec_op(0, -1, 0, 1, 30'h000, 4'b1100, 32'h0, 0, 32'hFFFF_8001);

        // Upstream exception wins over misalignment; its cause and tval pass through
        dbus_rdata = 32'h0;
        set_op(1, 0, 2'd2, 0, 32'h0000_0007, 32'h0, 30'h10A, 5'd2, 1, 4'd2);
        push_exp(0, 1, 4'd2, 30'h10A, 32'h0000_0007, 5'd2);
        exec_op(-1, -1, 0, 0, 30'h0, 4'h0, 32'h0, 0, 32'h0);

        // Reset while BUSY drops the request; a late ack afterwards is ignored
        set_op(0, 1, 2'd2, 0, 32'h0000_5000, 32'h1, 30'h10B, 5'd0, 0, '0);
        @(negedge clk);
        check("pre_rst_req", {31'd0, dbus_req}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("busy_stall", {31'd0, mem_stall}, 32'd1);
        reset = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_drop_req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        set_idle();
        dbus_ack = 1;
        @(negedge clk);
        check("late_ack_req", {31'd0, dbus_req}, 32'd0);
        check("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #1 dbus_ack = 0;
        @(negedge clk);
        check("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Normal operation resumes after the reset
        @(posedge clk);
        #1;
        dbus_rdata = 32'hCAFE_0042;
        set_op(1, 0, 2'd0, 0, 32'h0000_6000, 32'h0, 30'h10C, 5'd6, 0, '0);
        push_exp(1, 0, '0, 30'h10C, 32'h0000_0042, 5'd6);
        exec_op(0, -1, 0, 1, 30'h1800, 4'b0001, 32'h0, 0, 32'h0000_0042);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
